// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - decode/execute status in, pipeline register control out
interface pipeline_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_uses_rs;
    logic              id_uses_rt;
    logic              id_valid;
    logic              ex_mem_read;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_redirect;
    logic              irq;
    logic              kernel;

    logic              pc_write;
    logic              if_id_write;
    logic              if_id_flush;
    logic              id_ex_flush;
    logic              irq_take;
    logic              irq_pending;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, id_valid,
               ex_mem_read, ex_rd, ex_redirect, irq, kernel,
        input  pc_write, if_id_write, if_id_flush, id_ex_flush,
               irq_take, irq_pending, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_valid,
               ex_mem_read, ex_rd, ex_redirect, irq, kernel,
        output pc_write, if_id_write, if_id_flush, id_ex_flush,
               irq_take, irq_pending, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - load-use stall, redirect flush and IRQ injection control
module pipeline_hazard_ctrl #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    pipeline_hazard_ctrl_if.slave bus
);
    localparam int SCNT_W = $clog2(LOAD_LAT) + 1;

    localparam logic [SCNT_W-1:0] IDLE         = '0;
    localparam logic [SCNT_W-1:0] STALL_RELOAD = SCNT_W'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX      = '1;

    logic [SCNT_W-1:0] scnt;
    logic              irqPending;
    logic [CNT_W-1:0]  stallCnt;
    logic [CNT_W-1:0]  flushCnt;

    logic [REG_AW-1:0] exRd;
    logic              rsMatch;
    logic              rtMatch;
    logic              haz;
    logic              stalling;
    logic              redirect;
    logic              freeze;
    logic              take;

    assign exRd = bus.ex_rd;

    always_comb begin
        rsMatch  = bus.id_uses_rs && (exRd == bus.id_rs);
        rtMatch  = bus.id_uses_rt && (exRd == bus.id_rt);
        haz      = bus.ex_mem_read && bus.id_valid && (exRd != '0) && (rsMatch || rtMatch);
        stalling = (scnt != IDLE);
        redirect = bus.ex_redirect;
        // A redirect kills the stalled instruction, so it overrides any freeze.
        freeze   = !redirect && (stalling || haz);
        take     = !redirect && !freeze && irqPending && !bus.kernel && bus.id_valid;
    end

    assign bus.pc_write    = reset || !freeze;
    assign bus.if_id_write = reset || !freeze;
    assign bus.if_id_flush = !reset && (redirect || take);
    assign bus.id_ex_flush = !reset && (redirect || freeze);
    assign bus.irq_take    = !reset && take;
    assign bus.irq_pending = irqPending;
    assign bus.stall_cnt   = stallCnt;
    assign bus.flush_cnt   = flushCnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            scnt <= IDLE;
        end else if (redirect) begin
            scnt <= IDLE;
        end else if (stalling) begin
            scnt <= scnt - SCNT_W'(1);
        end else if (haz) begin
            // The hazard cycle itself is the first bubble.
            scnt <= STALL_RELOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irqPending <= 1'b0;
        end else if (take) begin
            irqPending <= 1'b0;
        end else if (bus.irq && !bus.kernel) begin
            irqPending <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (freeze && stallCnt != CNT_MAX) begin
                stallCnt <= stallCnt + CNT_W'(1);
            end
            if (redirect && flushCnt != CNT_MAX) begin
                flushCnt <= flushCnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
    typedef struct packed {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       usesRs;
        logic       usesRt;
        logic       idValid;
        logic       memRead;
        logic [4:0] exRd;
        logic       redirect;
        logic       irq;
        logic       kernel;
    } stim_t;

    typedef struct packed {
        logic pcW;
        logic ifW;
        logic ifF;
        logic idF;
        logic take;
        logic pend;
    } exp_t;

    localparam exp_t E_NORM = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam exp_t E_FRZ  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam exp_t E_RED  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam exp_t E_TAKE = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] idRs, idRt, exRd;
    logic       idUsesRs, idUsesRt, idValid, exMemRead, exRedirect, irq, kernel;

    int checks = 0;
    int errors = 0;

    stim_t stimQ[$];
    exp_t  expQ[$];

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) ifA ();
    pipeline_hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) ifB ();
    pipeline_hazard_ctrl_if #(.REG_AW(5), .CNT_W(4))  ifC ();

    assign ifA.id_rs = idRs;  assign ifA.id_rt = idRt;  assign ifA.id_uses_rs = idUsesRs;
    assign ifA.id_uses_rt = idUsesRt;  assign ifA.id_valid = idValid;  assign ifA.ex_mem_read = exMemRead;
    assign ifA.ex_rd = exRd;  assign ifA.ex_redirect = exRedirect;  assign ifA.irq = irq;  assign ifA.kernel = kernel;

    assign ifB.id_rs = idRs;  assign ifB.id_rt = idRt;  assign ifB.id_uses_rs = idUsesRs;
    assign ifB.id_uses_rt = idUsesRt;  assign ifB.id_valid = idValid;  assign ifB.ex_mem_read = exMemRead;
    assign ifB.ex_rd = exRd;  assign ifB.ex_redirect = exRedirect;  assign ifB.irq = irq;  assign ifB.kernel = kernel;

    assign ifC.id_rs = idRs;  assign ifC.id_rt = idRt;  assign ifC.id_uses_rs = idUsesRs;
    assign ifC.id_uses_rt = idUsesRt;  assign ifC.id_valid = idValid;  assign ifC.ex_mem_read = exMemRead;
    assign ifC.ex_rd = exRd;  assign ifC.ex_redirect = exRedirect;  assign ifC.irq = irq;  assign ifC.kernel = kernel;

    pipeline_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(16)) dutA (.clk(clk), .reset(reset), .bus(ifA.slave));
    pipeline_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(16)) dutB (.clk(clk), .reset(reset), .bus(ifB.slave));
    pipeline_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(2), .CNT_W(4))  dutC (.clk(clk), .reset(reset), .bus(ifC.slave));

    function automatic stim_t nop();
        stim_t s;
        s = '0;
        s.idValid = 1'b1;
        return s;
    endfunction

    function automatic stim_t lw8();
        stim_t s;
        s = nop();
        s.memRead = 1'b1;
        s.exRd    = 5'd8;
        s.rs      = 5'd8;
        s.usesRs  = 1'b1;
        return s;
    endfunction

    function automatic exp_t withPend(input exp_t e);
        exp_t r;
        r = e;
        r.pend = 1'b1;
        return r;
    endfunction

    function automatic exp_t sample(input int sel);
        exp_t g;
        case (sel)
            0:       g = '{ifA.pc_write, ifA.if_id_write, ifA.if_id_flush, ifA.id_ex_flush, ifA.irq_take, ifA.irq_pending};
            1:       g = '{ifB.pc_write, ifB.if_id_write, ifB.if_id_flush, ifB.id_ex_flush, ifB.irq_take, ifB.irq_pending};
            default: g = '{ifC.pc_write, ifC.if_id_write, ifC.if_id_flush, ifC.id_ex_flush, ifC.irq_take, ifC.irq_pending};
        endcase
        return g;
    endfunction

    task automatic drive(input stim_t s);
        reset = s.rst;  idRs = s.rs;  idRt = s.rt;  idUsesRs = s.usesRs;  idUsesRt = s.usesRt;
        idValid = s.idValid;  exMemRead = s.memRead;  exRd = s.exRd;  exRedirect = s.redirect;
        irq = s.irq;  kernel = s.kernel;
    endtask

    task automatic push(input stim_t s, input exp_t e);
        stimQ.push_back(s);
        expQ.push_back(e);
    endtask

    // Outputs are sampled 1 ns after the inputs change, midway between rising edges.
    task automatic runQueued(input int sel, input string name);
        stim_t s;
        exp_t  e, g;
        int    cyc;
        cyc = 0;
        while (stimQ.size() > 0) begin
            s = stimQ.pop_front();
            @(negedge clk);
            drive(s);
            #1;
            g = sample(sel);
            e = expQ.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL %s cycle %0d: got pc/ifw/iff/idf/take/pend=%b required %b", name, cyc, g, e);
            end
            cyc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        stim_t s;
        s = '0;
        s.rst = 1'b1;
        @(negedge clk);
        drive(s);
        @(posedge clk);
    endtask

    task automatic checkCnt(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        stim_t s;
        doReset();
        s = '0;
        push(s, E_NORM);
        runQueued(0, "reset_idle");
        checkCnt("reset_stall_cnt_A", ifA.stall_cnt, 16'd0);
        checkCnt("reset_flush_cnt_B", ifB.flush_cnt, 16'd0);
        checkCnt("reset_stall_cnt_C", {12'd0, ifC.stall_cnt}, 16'd0);
    endtask

    task automatic test_load_use_lat1();
        stim_t s;
        doReset();
        push(lw8(), E_FRZ);
        push(nop(), E_NORM);
        runQueued(0, "lat1_rs");
        checkCnt("lat1_stall_cnt", ifA.stall_cnt, 16'd1);
        s = lw8();  s.rs = 5'd3;  s.rt = 5'd8;  s.usesRt = 1'b1;
        push(s, E_FRZ);
        push(nop(), E_NORM);
        s.usesRt = 1'b0;
        push(s, E_NORM);
        s = lw8();  s.idValid = 1'b0;
        push(s, E_NORM);
        s = lw8();  s.memRead = 1'b0;
        push(s, E_NORM);
        push(nop(), E_NORM);
        runQueued(0, "lat1_rt_and_masks");
        checkCnt("lat1_stall_cnt_rt", ifA.stall_cnt, 16'd2);
    endtask

    task automatic test_load_use_lat3();
        stim_t s;
        doReset();
        push(lw8(), E_FRZ);
        push(lw8(), E_FRZ);
        push(lw8(), E_FRZ);
        push(nop(), E_NORM);
        s = lw8();  s.exRd = 5'd0;  s.rs = 5'd0;
        push(s, E_NORM);
        runQueued(1, "lat3_stall");
        checkCnt("lat3_stall_cnt", ifB.stall_cnt, 16'd3);
    endtask

    task automatic test_redirect_mid_stall();
        stim_t s;
        doReset();
        push(lw8(), E_FRZ);
        push(lw8(), E_FRZ);
        s = lw8();  s.redirect = 1'b1;
        push(s, E_RED);
        s = nop();
        push(s, E_NORM);
        runQueued(1, "redirect_mid_stall");
        checkCnt("redirect_stall_cnt", ifB.stall_cnt, 16'd2);
        checkCnt("redirect_flush_cnt", ifB.flush_cnt, 16'd1);
    endtask

    task automatic test_irq_pulse();
        stim_t s;
        doReset();
        s = nop();  s.irq = 1'b1;
        push(s, E_NORM);
        push(nop(), E_TAKE);
        push(nop(), E_NORM);
        push(nop(), E_NORM);
        push(s, E_NORM);
        push(s, E_TAKE);
        push(nop(), E_NORM);
        runQueued(0, "irq_pulse");
    endtask

    task automatic test_irq_kernel();
        stim_t s;
        doReset();
        s = nop();  s.irq = 1'b1;  s.kernel = 1'b1;
        for (int i = 0; i < 4; i++) push(s, E_NORM);
        push(nop(), E_NORM);
        runQueued(0, "irq_kernel_masked");
    endtask

    task automatic test_irq_during_stall();
        stim_t s;
        doReset();
        s = lw8();  s.irq = 1'b1;
        push(s, E_FRZ);
        s = lw8();  s.memRead = 1'b0;
        push(s, withPend(E_FRZ));
        push(nop(), E_TAKE);
        push(nop(), E_NORM);
        runQueued(2, "irq_during_stall");
    endtask

    task automatic test_irq_redirect();
        stim_t s;
        doReset();
        s = nop();  s.irq = 1'b1;
        push(s, E_NORM);
        s = nop();  s.redirect = 1'b1;
        push(s, withPend(E_RED));
        push(nop(), E_TAKE);
        push(nop(), E_NORM);
        runQueued(0, "irq_redirect");
    endtask

    task automatic test_reset_mid_stall();
        stim_t s;
        doReset();
        s = nop();  s.redirect = 1'b1;
        push(s, E_RED);
        push(lw8(), E_FRZ);
        s = lw8();  s.rst = 1'b1;
        push(s, E_NORM);
        s = lw8();  s.memRead = 1'b0;
        push(s, E_NORM);
        runQueued(1, "reset_mid_stall");
        checkCnt("reset_mid_stall_cnt", ifB.stall_cnt, 16'd0);
        checkCnt("reset_mid_flush_cnt", ifB.flush_cnt, 16'd0);
    endtask

    task automatic test_back_to_back();
        stim_t s;
        doReset();
        for (int i = 0; i < 21; i++) push(lw8(), E_FRZ);
        runQueued(2, "stall_saturate");
        checkCnt("stall_cnt_saturated", {12'd0, ifC.stall_cnt}, 16'd15);
        s = nop();  s.redirect = 1'b1;
        for (int i = 0; i < 21; i++) push(s, E_RED);
        runQueued(2, "flush_saturate");
        checkCnt("flush_cnt_saturated", {12'd0, ifC.flush_cnt}, 16'd15);
        checkCnt("stall_cnt_held", {12'd0, ifC.stall_cnt}, 16'd15);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive('0);
        test_reset();
        test_load_use_lat1();
        test_load_use_lat3();
        test_redirect_mid_stall();
        test_irq_pulse();
        test_irq_kernel();
        test_irq_during_stall();
        test_irq_redirect();
        test_reset_mid_stall();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
